// File: rtl/datamover_tcdm_responder_pkg.sv
// Shared types and constants for the datamover TCDM responder.
package datamover_tcdm_resp_package;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DEFAULT_DW = 288;

  // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1 (taps on bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Response entry at the default width; parameterised instances build their own.
  typedef struct packed {
    logic [DEFAULT_DW-1:0] data;
    logic                  err;
  } resp_t;

  function automatic int unsigned n_lanes(input int unsigned dw);
    return dw / WORD_W;
  endfunction

endpackage

// File: rtl/datamover_tcdm_responder_fifo.sv
// Synchronous response FIFO with occupancy count and synchronous clear.
module datamover_tcdm_resp_fifo
  import datamover_tcdm_resp_package::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = resp_t,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  T                 data_i,
  output T                 data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; clear wins over push/pop.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = bump(wr_ptr_q);
      if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/datamover_tcdm_responder.sv
// TCDM target for the datamover: N_LANES interleaved 32-bit words per request,
// in-order read responses through a backpressurable FIFO.
// Optional feature macro: DATAMOVER_TCDM_RESP_STALL_EN (LFSR-driven grant stalls).
module datamover_tcdm_responder
  import datamover_tcdm_resp_package::*;
#(
  parameter int unsigned DW         = 288,
  parameter int unsigned AW         = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   add_i,
  input  logic            wen_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   data_i,
  output logic            r_valid_o,
  input  logic            r_ready_i,
  output logic [DW-1:0]   r_data_o,
  output logic            r_err_o,
  output logic            err_o
);

  localparam int unsigned N_LANES = n_lanes(DW);
  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W   = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } lane_resp_t;

  logic [31:0]      mem_q [MEM_WORDS];
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] lane_idx [N_LANES];
  logic [DW-1:0]    rd_data;
  logic             misaligned, stall, wr_en, rd_push, rd_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  lane_resp_t       push_resp, head_resp;
  logic             err_q, err_d;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^add_i[AW-1:IDX_W+2];

  assign base_idx   = add_i[IDX_W+1:2];
  assign misaligned = (add_i[1:0] != 2'b00);

  // Outstanding cap uses the registered count, so a full FIFO popping this cycle still blocks reads.
  assign gnt_o   = req_i & ~clear_i & ~stall & (~wen_i | (fifo_cnt < CNT_W'(RESP_DEPTH)));
  assign wr_en   = gnt_o & ~wen_i & ~misaligned;
  assign rd_push = gnt_o & wen_i;
  assign rd_pop  = r_valid_o & r_ready_i;

`ifdef DATAMOVER_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR advances every cycle and restarts from the seed on clear.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    if (clear_i) lfsr_d = LFSR_SEED;
  end

  // LFSR register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Lane addressing with wrap at the top of storage, and combinational read.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      lane_idx[k]          = base_idx + IDX_W'(k);
      rd_data[32*k +: 32]  = mem_q[lane_idx[k]];
    end
  end

  // Byte-enabled lane writes; the array is written in place rather than via a
  // full-array _d copy, and deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < N_LANES; k++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be_i[4*k+b]) mem_q[lane_idx[k]][8*b +: 8] <= data_i[32*k+8*b +: 8];
        end
      end
    end
  end

  // Response entry: misaligned reads return zero data flagged as error.
  always_comb begin
    push_resp.data = misaligned ? '0 : rd_data;
    push_resp.err  = misaligned;
  end

  datamover_tcdm_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (lane_resp_t)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (rd_push),
    .pop_i   (rd_pop),
    .data_i  (push_resp),
    .data_o  (head_resp),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign r_valid_o = ~fifo_empty;
  assign r_data_o  = r_valid_o ? head_resp.data : '0;
  assign r_err_o   = r_valid_o & head_resp.err;

  // Sticky misaligned-access flag.
  always_comb begin
    err_d = err_q | (gnt_o & misaligned);
    if (clear_i) err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_datamover_tcdm_responder.sv
// Self-checking bench for datamover_tcdm_responder with a word-array reference model.
module tb_datamover_tcdm_responder;

  localparam int DW = 288;
  localparam int NL = DW / 32;
  localparam int AW = 32;
  localparam int MW = 1024;
  localparam int RD = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni, clear_i, req_i, gnt_o, wen_i;
  logic            r_valid_o, r_ready_i, r_err_o, err_o;
  logic [AW-1:0]   add_i;
  logic [DW/8-1:0] be_i;
  logic [DW-1:0]   data_i, r_data_o;

  always #5 clk_i = ~clk_i;

  datamover_tcdm_responder #(
    .DW (DW), .AW (AW), .MEM_WORDS (MW), .RESP_DEPTH (RD)
  ) dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .clear_i (clear_i), .req_i (req_i), .gnt_o (gnt_o),
    .add_i (add_i), .wen_i (wen_i), .be_i (be_i), .data_i (data_i),
    .r_valid_o (r_valid_o), .r_ready_i (r_ready_i), .r_data_o (r_data_o),
    .r_err_o (r_err_o), .err_o (err_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_mem [MW];
  exp_t        exp_q [$];
  logic        err_exp = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: applied at the moment a grant is observed.
  task automatic model_grant();
    exp_t e;
    int   base;
    base = int'(add_i[11:2]);
    if (add_i[1:0] != 2'b00) begin
      err_exp = 1'b1;
      if (wen_i) begin
        e.data = '0; e.err = 1'b1; exp_q.push_back(e);
      end
    end else if (wen_i) begin
      for (int k = 0; k < NL; k++) e.data[32*k +: 32] = ref_mem[(base + k) % MW];
      e.err = 1'b0;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < NL; k++)
        for (int b = 0; b < 4; b++)
          if (be_i[4*k+b]) ref_mem[(base + k) % MW][8*b +: 8] = data_i[32*k+8*b +: 8];
    end
  endtask

  // Response checker: every accepted response must match the oldest expected one.
  always @(negedge clk_i) begin
    if (rst_ni && r_valid_o && r_ready_i) begin
      if (exp_q.size() == 0) chk("resp_unexpected", DW'(r_valid_o), '0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_data", r_data_o, e.data);
        chk("resp_err", DW'(r_err_o), DW'(e.err));
      end
    end
  end

  task automatic xfer(input logic wen, input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                      input logic [DW-1:0] data, input int limit, output bit granted);
    req_i = 1'b1; wen_i = wen; add_i = addr; be_i = be; data_i = data; granted = 1'b0;
    for (int c = 0; c < limit && !granted; c++) begin
      @(negedge clk_i);
      if (gnt_o) begin
        model_grant();
        granted = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    req_i = 1'b0;
  endtask

  task automatic req_ok(input logic wen, input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                        input logic [DW-1:0] data);
    bit g;
    xfer(wen, addr, be, data, 64, g);
    chk("grant_timeout", DW'(g), DW'(1));
  endtask

  task automatic latency_check(input logic [DW-1:0] expv);
    @(negedge clk_i);
    chk("lat_valid", DW'(r_valid_o), DW'(1));
    chk("lat_data", r_data_o, expv);
    chk("lat_err", DW'(r_err_o), '0);
    @(posedge clk_i); #1;
  endtask

  task automatic drain(input int limit);
    for (int c = 0; c < limit && exp_q.size() != 0; c++) @(negedge clk_i);
    chk("drain", DW'(exp_q.size()), '0);
    @(posedge clk_i); #1;
  endtask

  task automatic rand_op();
    wen_i = 1'($urandom_range(0, 1));
    add_i = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(0, 15) == 0) add_i[1:0] = 2'($urandom_range(1, 3));
    for (int w = 0; w < NL; w++) data_i[32*w +: 32] = $urandom();
    for (int b = 0; b < DW/8; b++) be_i[b] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pat, wdata, expv;
    logic [DW/8-1:0] be;
    bit   g, gl;
    int   n, stalls, cyc;

    rst_ni = 1'b0; clear_i = 1'b0; req_i = 1'b0; wen_i = 1'b0;
    add_i = '0; be_i = '0; data_i = '0; r_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", DW'(gnt_o), '0);
    chk("rst_valid", DW'(r_valid_o), '0);
    chk("rst_data", r_data_o, '0);
    chk("rst_rerr", DW'(r_err_o), '0);
    chk("rst_err", DW'(err_o), '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Zero the whole storage through the port.
    for (int i = 0; i < 114; i++) req_ok(1'b0, AW'(i * 36), '1, '0);

    // Full-word pattern write then read back.
    for (int k = 0; k < NL; k++) pat[32*k +: 32] = 32'(k) * 32'h0101_0101;
    req_ok(1'b0, 32'h0, '1, pat);
    req_ok(1'b1, 32'h0, '0, '0);
    latency_check(pat);

    // Byte-0-only write over zeroed words 1..9.
    req_ok(1'b0, 32'h4, '1, '0);
    be = '0;
    for (int k = 0; k < NL; k++) be[4*k] = 1'b1;
    req_ok(1'b0, 32'h4, be, '1);
    for (int k = 0; k < NL; k++) expv[32*k +: 32] = 32'h0000_00FF;
    req_ok(1'b1, 32'h4, '1, '0);
    latency_check(expv);

    // Wrap-around: base word MW-2 spills lanes 2.. into words 0..
    for (int w = 0; w < NL; w++) wdata[32*w +: 32] = $urandom();
    req_ok(1'b0, AW'((MW - 2) * 4), '1, wdata);
    req_ok(1'b1, AW'((MW - 2) * 4), '0, '0);
    latency_check(wdata);
    req_ok(1'b1, 32'h0, '0, '0);
    @(negedge clk_i);
    chk("wrap_word0", DW'(r_data_o[31:0]), DW'(wdata[95:64]));
    @(posedge clk_i); #1;

    // Backpressure: four reads fill the FIFO, fifth read blocked, writes still accepted.
    r_ready_i = 1'b0;
    for (int i = 0; i < RD; i++) req_ok(1'b1, $urandom() & 32'hFFFF_FFFC, '0, '0);
    xfer(1'b1, 32'h40, '0, '0, 10, gl);
    chk("read_cap", DW'(gl), '0);
    req_ok(1'b0, 32'h80, '1, '1);
    @(negedge clk_i);
    chk("hold_valid", DW'(r_valid_o), DW'(1));
    chk("hold_data", r_data_o, exp_q[0].data);
    chk("outstanding", DW'(exp_q.size()), DW'(RD));
    @(posedge clk_i); #1;
    r_ready_i = 1'b1;
    drain(40);
    req_ok(1'b1, 32'h40, '0, '0);
    req_ok(1'b1, 32'h44, '0, '0);
    drain(40);

    // Misaligned accesses and sticky error with clear.
    req_ok(1'b1, 32'h2, '0, '0);
    @(negedge clk_i);
    chk("mis_rerr", DW'(r_err_o), DW'(1));
    chk("mis_data", r_data_o, '0);
    chk("mis_err", DW'(err_o), DW'(1));
    @(posedge clk_i); #1;
    req_ok(1'b0, 32'h6, '1, '1);
    req_ok(1'b1, 32'h4, '0, '0);
    drain(40);
    clear_i = 1'b1; req_i = 1'b1; wen_i = 1'b1; add_i = 32'h0;
    @(negedge clk_i);
    chk("clear_gnt", DW'(gnt_o), '0);
    chk("err_before_clear", DW'(err_o), DW'(1));
    @(posedge clk_i); #1;
    clear_i = 1'b0; req_i = 1'b0; err_exp = 1'b0;
    @(negedge clk_i);
    chk("err_after_clear", DW'(err_o), '0);
    @(posedge clk_i); #1;

    // 100 back-to-back reads with the consumer always ready.
    n = 0; stalls = 0; cyc = 0; g = 1'b0;
    req_i = 1'b1; wen_i = 1'b1; add_i = $urandom() & 32'hFFFF_FFFC;
    while (n < 100 && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
      g = gnt_o;
      if (g) begin model_grant(); n++; end
      else stalls++;
      @(posedge clk_i); #1;
      if (g) add_i = $urandom() & 32'hFFFF_FFFC;
    end
    req_i = 1'b0;
    chk("burst_count", DW'(n), DW'(100));
`ifdef DATAMOVER_TCDM_RESP_STALL_EN
    chk("stall_rate", DW'((stalls * 100 >= cyc * 10) && (stalls * 100 <= cyc * 45)), DW'(1));
`else
    chk("no_stall", DW'(stalls), '0);
`endif
    drain(40);

    // Mixed random traffic with a randomly stalling consumer.
    n = 0; cyc = 0;
    req_i = 1'b1; rand_op();
    while (n < 120 && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      g = gnt_o;
      if (g) begin model_grant(); n++; end
      @(posedge clk_i); #1;
      r_ready_i = ($urandom_range(0, 3) != 0);
      if (g) rand_op();
    end
    req_i = 1'b0; r_ready_i = 1'b1;
    chk("mixed_count", DW'(n), DW'(120));
    drain(40);
    chk("mixed_err", DW'(err_o), DW'(err_exp));

    // Reset with pending responses drops them.
    r_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) req_ok(1'b1, AW'(i * 4), '0, '0);
    chk("pending3", DW'(exp_q.size()), DW'(3));
    rst_ni = 1'b0;
    exp_q.delete();
    err_exp = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_valid", DW'(r_valid_o), '0);
    chk("rst_mid_data", r_data_o, '0);
    chk("rst_mid_err", DW'(err_o), '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; r_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("post_rst_valid", DW'(r_valid_o), '0);
    chk("final_drain", DW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
